// File: rtl/axi_burst_master.sv
// axi_burst_master
//   Single-outstanding AXI4 INCR burst initiator (1-bit ID, 32-bit data).
//   A local command (write/read, address, beats-1) becomes one burst.
//   Write beats come in on a valid/ready stream; read beats leave on one.
//   Completion is reported by a one-cycle `done` pulse with `done_resp`.
//   Optional feature macro: AXIM_ERR_STICKY_EN adds err_sticky/err_clr.
`timescale 1ns/1ps
module axi_burst_master #(
    parameter logic       AXI_ID    = 1'b0,
    parameter logic [2:0] BEAT_SIZE = 3'd2
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    input  logic        rd_ready,
    output logic        done,
    output logic [1:0]  done_resp,
`ifdef AXIM_ERR_STICKY_EN
    output logic        err_sticky,
    input  logic        err_clr,
`endif
    output logic        AWID,
    output logic [31:0] AWADDR,
    output logic [7:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic        WID,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic        BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output logic        ARID,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic        RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [31:0] addr_r;
    logic [7:0]  len_r;
    logic        awvalid_r;
    logic        arvalid_r;
    logic [31:0] wdata_r;
    logic        wvalid_r;
    logic        wlast_r;
    logic [7:0]  w_idx_r;
    logic        w_all_r;
    logic [7:0]  r_cnt_r;
    logic [1:0]  r_resp_r;
    logic        done_r;
    logic [1:0]  done_resp_r;

    logic        cmd_hs_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        w_load_s;
    logic        b_hs_s;
    logic        ar_hs_s;
    logic        r_hs_s;
    logic        r_end_s;
    logic [1:0]  r_resp_next_s;
    logic        unused_s;

    // Worst-case combine of two AXI responses (DECERR > SLVERR > EXOKAY > OKAY)
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

    assign cmd_ready = (state_r == S_IDLE);
    assign cmd_hs_s  = cmd_valid && cmd_ready;
    assign aw_hs_s   = awvalid_r && AWREADY;
    assign ar_hs_s   = arvalid_r && ARREADY;
    assign w_hs_s    = wvalid_r && WREADY;
    // The output register may refill in the same cycle its beat is taken.
    assign wr_ready  = (state_r == S_W) && !w_all_r && (!wvalid_r || WREADY);
    assign w_load_s  = wr_ready && wr_valid;
    assign BREADY    = (state_r == S_B);
    assign b_hs_s    = BVALID && BREADY;
    assign RREADY    = (state_r == S_R) ? rd_ready : 1'b0;
    assign r_hs_s    = RVALID && RREADY;
    assign r_end_s   = r_hs_s && RLAST;

    assign AWID    = AXI_ID;
    assign AWADDR  = addr_r;
    assign AWLEN   = len_r;
    assign AWSIZE  = BEAT_SIZE;
    assign AWBURST = 2'b01;
    assign AWVALID = awvalid_r;
    assign WID     = AXI_ID;
    assign WDATA   = wdata_r;
    assign WSTRB   = 4'hF;
    assign WLAST   = wlast_r;
    assign WVALID  = wvalid_r;
    assign ARID    = AXI_ID;
    assign ARADDR  = addr_r;
    assign ARLEN   = len_r;
    assign ARSIZE  = BEAT_SIZE;
    assign ARBURST = 2'b01;
    assign ARVALID = arvalid_r;

    assign rd_data   = RDATA;
    assign rd_last   = RLAST;
    assign rd_valid  = (state_r == S_R) && RVALID;
    assign done      = done_r;
    assign done_resp = done_resp_r;

    // Response IDs are not checked: only one burst is ever outstanding.
    assign unused_s = ^{BID, RID};

    // Read response merge: early RLAST is a protocol error, otherwise keep the worst
    always_comb begin
        r_resp_next_s = resp_max(r_resp_r, RRESP);
        if (RLAST && (r_cnt_r != len_r)) begin
            r_resp_next_s = 2'b10;
        end else begin
            r_resp_next_s = resp_max(r_resp_r, RRESP);
        end
    end

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_hs_s) begin
                    state_next_s = cmd_write ? S_AW : S_AR;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_AW: begin
                if (aw_hs_s) begin
                    state_next_s = S_W;
                end else begin
                    state_next_s = S_AW;
                end
            end
            S_W: begin
                if (w_hs_s && wlast_r) begin
                    state_next_s = S_B;
                end else begin
                    state_next_s = S_W;
                end
            end
            S_B: begin
                if (b_hs_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_B;
                end
            end
            S_AR: begin
                if (ar_hs_s) begin
                    state_next_s = S_R;
                end else begin
                    state_next_s = S_AR;
                end
            end
            S_R: begin
                if (r_end_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_R;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Command capture and address-channel VALIDs (held with stable payload until READY)
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_r    <= 32'h0000_0000;
            len_r     <= 8'h00;
            awvalid_r <= 1'b0;
            arvalid_r <= 1'b0;
        end else if (cmd_hs_s) begin
            addr_r    <= cmd_addr;
            len_r     <= cmd_len;
            awvalid_r <= cmd_write;
            arvalid_r <= !cmd_write;
        end else begin
            if (aw_hs_s) begin
                awvalid_r <= 1'b0;
            end
            if (ar_hs_s) begin
                arvalid_r <= 1'b0;
            end
        end
    end

    // One-entry W output register; w_all_r marks that the final beat has been loaded
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wdata_r  <= 32'h0000_0000;
            wvalid_r <= 1'b0;
            wlast_r  <= 1'b0;
            w_idx_r  <= 8'h00;
            w_all_r  <= 1'b0;
        end else if (cmd_hs_s) begin
            w_idx_r  <= 8'h00;
            w_all_r  <= 1'b0;
        end else if (w_load_s) begin
            wdata_r  <= wr_data;
            wvalid_r <= 1'b1;
            wlast_r  <= (w_idx_r == len_r);
            w_idx_r  <= w_idx_r + 8'd1;
            if (w_idx_r == len_r) begin
                w_all_r <= 1'b1;
            end
        end else if (w_hs_s) begin
            wvalid_r <= 1'b0;
            wlast_r  <= 1'b0;
        end
    end

    // Read beat counter and running worst response
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_cnt_r  <= 8'h00;
            r_resp_r <= 2'b00;
        end else if (cmd_hs_s) begin
            r_cnt_r  <= 8'h00;
            r_resp_r <= 2'b00;
        end else if (r_hs_s) begin
            r_cnt_r  <= r_cnt_r + 8'd1;
            r_resp_r <= r_resp_next_s;
        end
    end

    // Completion pulse and its response, registered as the FSM returns to idle
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            done_r      <= 1'b0;
            done_resp_r <= 2'b00;
        end else begin
            done_r <= b_hs_s || r_end_s;
            if (b_hs_s) begin
                done_resp_r <= BRESP;
            end else if (r_end_s) begin
                done_resp_r <= r_resp_next_s;
            end
        end
    end

`ifdef AXIM_ERR_STICKY_EN
    logic err_sticky_r;

    // Sticky error flag: set by any errored completion, err_clr has priority
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_sticky_r <= 1'b0;
        end else if (err_clr) begin
            err_sticky_r <= 1'b0;
        end else if (done_r && (done_resp_r != 2'b00)) begin
            err_sticky_r <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_r;
`endif

endmodule
